shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 98 +++++++++
 tb/tb_shift_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// shift_seq: sequential shifter, one bit position per cycle, with valid/ready handshakes.
// Rotate mode is compiled in only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_seq #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             op,
    input  logic             rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] q;
    logic [SHW-1:0]   cnt;
    logic             mode_dir;
    logic             mode_op;
    logic [WIDTH-1:0] q_step;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic             mode_rot;
`else
    logic             unused_rot;
    assign unused_rot = rot;
`endif

    // One-bit step; rotate (when built in) takes priority over arithmetic/logical.
    always_comb begin
        if (mode_dir) begin
            q_step = {q[WIDTH-2:0], 1'b0};
        end else begin
            q_step = {mode_op & q[WIDTH-1], q[WIDTH-1:1]};
        end
`ifdef SHIFT_SEQ_ROTATE_EN
        if (mode_rot) begin
            q_step = mode_dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            q        <= '0;
            cnt      <= '0;
            mode_dir <= 1'b0;
            mode_op  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            mode_rot <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        q        <= din;
                        cnt      <= shamt;
                        mode_dir <= dir;
                        mode_op  <= op;
`ifdef SHIFT_SEQ_ROTATE_EN
                        mode_rot <= rot;
`endif
                        state    <= (shamt == '0) ? StDone : StShift;
                    end
                end
                StShift: begin
                    q   <= q_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);
    assign busy      = (state != StIdle);
    assign dout      = q;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: transaction-level reference model checked every cycle, plus
// directed cases with literal expectations.
module tb_shift_seq;

    localparam int unsigned W   = 8;
    localparam int unsigned SHW = $clog2(W);

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   din;
    logic [SHW-1:0] shamt;
    logic           dir;
    logic           op;
    logic           rot;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   dout;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    shift_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .dir       (dir),
        .op        (op),
        .rot       (rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single-cycle barrel-shift reference.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh,
                                               input logic dr, input logic ar, input logic r);
        logic signed [W-1:0] s;
        logic signed [W-1:0] t;
        s = d;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (r) return dr ? ((d << sh) | (d >> (W - sh))) : ((d >> sh) | (d << (W - sh)));
`else
        if (r && 1'b0) return '0;
`endif
        if (dr) return d << sh;
        if (ar) begin
            t = s >>> sh;
            return t;
        end
        return d >> sh;
    endfunction

    // Transaction model: busy from accept until released; result visible shamt edges
    // after the accept edge.
    logic         m_busy;
    logic [W-1:0] m_res;
    int           m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_res  <= '0;
            m_done <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_res  <= ref_shift(din, int'(shamt), dir, op, rot);
                m_done <= cyc + 1 + int'(shamt);
            end
        end else if (cyc >= m_done && out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic exp_ov;
        exp_ov = m_busy && (cyc >= m_done);
        check("in_ready", in_ready, !m_busy);
        check("busy", busy, m_busy);
        check("out_valid", out_valid, exp_ov);
        if (!m_busy || exp_ov) check("dout", dout, m_res);
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("wait in_ready timeout", 0, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) check("wait out_valid timeout", 0, 1);
    endtask

    task automatic run_one(input string name, input logic [W-1:0] d, input int sh,
                           input logic dr, input logic ar, input logic r,
                           input logic [W-1:0] exp);
        int n;
        wait_idle();
        in_valid = 1'b1;
        din      = d;
        shamt    = SHW'(sh);
        dir      = dr;
        op       = ar;
        rot      = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        check({name, " latency"}, n, sh);
        check({name, " dout"}, dout, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b1; in_valid = 1'b0; din = '0; shamt = '0;
        dir = 1'b0; op = 1'b0; rot = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset dout", dout, 0);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_one("lsr3", 8'h96, 3, 1'b0, 1'b0, 1'b0, 8'h12);
        run_one("asr3", 8'h96, 3, 1'b0, 1'b1, 1'b0, 8'hF2);
        run_one("lsl3", 8'h96, 3, 1'b1, 1'b0, 1'b0, 8'hB0);
        run_one("asl3", 8'h96, 3, 1'b1, 1'b1, 1'b0, 8'hB0);
        run_one("sh0", 8'h96, 0, 1'b0, 1'b0, 1'b0, 8'h96);
        run_one("asr7", 8'h96, 7, 1'b0, 1'b1, 1'b0, 8'hFF);
`ifdef SHIFT_SEQ_ROTATE_EN
        run_one("rotr3", 8'h96, 3, 1'b0, 1'b0, 1'b1, 8'hD2);
        run_one("rotl3", 8'h96, 3, 1'b1, 1'b0, 1'b1, 8'hB4);
`else
        run_one("rotr3", 8'h96, 3, 1'b0, 1'b0, 1'b1, 8'h12);
        run_one("rotl3", 8'h96, 3, 1'b1, 1'b0, 1'b1, 8'hB0);
`endif

        // Backpressure: result held while out_ready is low, new request refused.
        wait_idle();
        out_ready = 1'b0;
        in_valid = 1'b1; din = 8'h96; shamt = 3'd3; dir = 1'b1; op = 1'b0; rot = 1'b0;
        @(posedge clk);
        #1;
        din = 8'h55; shamt = 3'd2; dir = 1'b0;
        wait_valid(n);
        check("hold dout", dout, 8'hB0);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold dout", dout, 8'hB0);
            check("hold in_ready", in_ready, 0);
            check("hold out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release out_valid", out_valid, 0);
        check("release in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("next accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_valid(n);
        check("next dout", dout, 8'h15);

        // Reset mid-shift discards the request.
        wait_idle();
        in_valid = 1'b1; din = 8'hFF; shamt = 3'd5; dir = 1'b0; op = 1'b0; rot = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort dout", dout, 0);
        check("abort out_valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("no stale out_valid", out_valid, 0);
        end

        // Random traffic with random backpressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            din       = W'($urandom);
            shamt     = SHW'($urandom);
            dir       = 1'($urandom_range(0, 1));
            op        = 1'($urandom_range(0, 1));
            rot       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
